// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared constants, direction codes and state encoding for the snake step sequencer
// Purpose: single source for field geometry, body depth, direction codes and sequencer states.
package snake_pkg;

    localparam int MAX_LEN = 128;
    localparam int AW      = $clog2(MAX_LEN);
    localparam int CW      = AW + 1;
    localparam int XW      = 10;
    localparam int YW      = 9;

    localparam logic [XW-1:0] CELL_X  = 10'd10;
    localparam logic [YW-1:0] CELL_Y  = 9'd10;
    localparam logic [XW-1:0] X_MIN   = 10'd10;
    localparam logic [XW-1:0] X_MAX   = 10'd620;
    localparam logic [YW-1:0] Y_MIN   = 9'd10;
    localparam logic [YW-1:0] Y_MAX   = 9'd460;
    localparam logic [XW-1:0] START_X = 10'd320;
    localparam logic [YW-1:0] START_Y = 9'd240;
    localparam logic [AW-1:0] LEN_MAX = AW'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT, S_CALC, S_SCAN, S_SHIFT, S_HEAD, S_OVER
    } state_e;

    // Opposite directions differ only in bit 1 (right<->left, down<->up).
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_body_ram.sv
// rtl/snake_body_ram.sv - single-port body RAM, one {x,y} entry per segment, 1-cycle read latency
// Ports: clk; addr/we/wx/wy write or read request; rx/ry data of the address presented last cycle.
module snake_body_ram
    import snake_pkg::*;
(
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [XW-1:0] wx,
    input  logic [YW-1:0] wy,
    output logic [XW-1:0] rx,
    output logic [YW-1:0] ry
);

    logic [XW+YW-1:0] mem [MAX_LEN];
    logic [XW+YW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {wx, wy};
        end
        rd_q <= mem[addr];
    end

    assign rx = rd_q[XW+YW-1:YW];
    assign ry = rd_q[YW-1:0];

endmodule

// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - sequencer for one snake move: border/self check, body shift, head write
// Ports: clk/rst; start level, tick step request, dir code, grow pulse;
//        mem_* single-port body RAM interface; length/head_x/head_y status;
//        busy while stepping, step_done pulse, sticky game_over.
module snake_step_ctrl
    import snake_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          tick,
    input  logic [2:0]    dir,
    input  logic          grow,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [XW-1:0] mem_wx,
    output logic [YW-1:0] mem_wy,
    input  logic [XW-1:0] mem_rx,
    input  logic [YW-1:0] mem_ry,
    output logic [AW-1:0] length,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic          busy,
    output logic          step_done,
    output logic          game_over
);

    state_e        state_q, state_d;
    dir_e          cur_dir_q, cur_dir_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic [AW-1:0] length_q, length_d;
    logic          grow_pend_q, grow_pend_d;
    logic          g_q, g_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          game_over_q, game_over_d;
    logic          step_done_q, step_done_d;

    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          hit_wall;
    logic          hit_body;
    logic          g_now;
    logic [CW-1:0] n_move;

    // Head and direction are frozen outside WAIT/HEAD, so the candidate head
    // stays valid combinationally for the whole step without its own register.
    always_comb begin
        nx = head_x_q;
        ny = head_y_q;
        case (cur_dir_q)
            DIR_RIGHT: nx = head_x_q + CELL_X;
            DIR_DOWN:  ny = head_y_q + CELL_Y;
            DIR_LEFT:  nx = head_x_q - CELL_X;
            default:   ny = head_y_q - CELL_Y;
        endcase
    end

    // Underflow wraps high, so a plain unsigned compare catches both edges.
    assign hit_wall = (nx < X_MIN) || (nx > X_MAX) || (ny < Y_MIN) || (ny > Y_MAX);
    assign g_now    = grow_pend_q && (length_q != LEN_MAX);
    // Entries to move this step; the scan covers 0..n_move-1 (tail excluded unless growing).
    assign n_move   = {1'b0, length_q} + CW'(g_q);
    // Read data lags the address by one cycle, so cnt_q compares entry cnt_q-1.
    assign hit_body = (cnt_q != '0) && (mem_rx == nx) && (mem_ry == ny);

    always_comb begin
        state_d     = state_q;
        cur_dir_d   = cur_dir_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        length_d    = length_q;
        grow_pend_d = grow_pend_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        game_over_d = game_over_q;
        step_done_d = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wx      = '0;
        mem_wy      = '0;

        if (!start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_INIT;
                S_INIT: begin
                    mem_we      = 1'b1;
                    mem_wx      = START_X;
                    mem_wy      = START_Y;
                    head_x_d    = START_X;
                    head_y_d    = START_Y;
                    length_d    = '0;
                    game_over_d = 1'b0;
                    grow_pend_d = 1'b0;
                    cur_dir_d   = DIR_RIGHT;
                    state_d     = S_WAIT;
                end
                S_WAIT: begin
                    if (tick) begin
                        if (!dir[2] && !is_reverse(dir[1:0], cur_dir_q)) begin
                            cur_dir_d = dir_e'(dir[1:0]);
                        end
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    g_d     = g_now;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    if (hit_wall) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else if (length_q == '0 && !g_now) begin
                        state_d = S_HEAD;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
                S_SCAN: begin
                    mem_addr = cnt_q[AW-1:0];
                    if (hit_body) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else if (cnt_q == n_move) begin
                        cnt_d   = n_move;
                        state_d = S_SHIFT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHIFT: begin
                    // Phase 0 reads entry i-1, phase 1 writes it to entry i.
                    if (!phase_q) begin
                        mem_addr = AW'(cnt_q - CW'(1));
                        phase_d  = 1'b1;
                    end else begin
                        mem_addr = cnt_q[AW-1:0];
                        mem_we   = 1'b1;
                        mem_wx   = mem_rx;
                        mem_wy   = mem_ry;
                        phase_d  = 1'b0;
                        cnt_d    = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = S_HEAD;
                        end
                    end
                end
                S_HEAD: begin
                    mem_we      = 1'b1;
                    mem_wx      = nx;
                    mem_wy      = ny;
                    head_x_d    = nx;
                    head_y_d    = ny;
                    length_d    = length_q + AW'(g_q);
                    step_done_d = 1'b1;
                    if (g_q) begin
                        grow_pend_d = 1'b0;
                    end
                    state_d = S_WAIT;
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end

        // A fresh apple wins over the clear in HEAD so it is not lost.
        if (grow && state_q != S_IDLE && state_q != S_INIT) begin
            grow_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_dir_q   <= DIR_RIGHT;
            head_x_q    <= START_X;
            head_y_q    <= START_Y;
            length_q    <= '0;
            grow_pend_q <= 1'b0;
            g_q         <= 1'b0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            game_over_q <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_dir_q   <= cur_dir_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            length_q    <= length_d;
            grow_pend_q <= grow_pend_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            game_over_q <= game_over_d;
            step_done_q <= step_done_d;
        end
    end

    assign length    = length_q;
    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign busy      = !(state_q inside {S_IDLE, S_WAIT, S_OVER});
    assign step_done = step_done_q;
    assign game_over = game_over_q;

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Sequencer for one snake movement step; replaces the per-tick 128-entry parallel shift with a single-port body RAM walked one entry per cycle.
- On each update tick it latches direction and growth, computes the new head, checks border and self-collision, shifts the body, writes the head, and reports length and game-over state.
- Sits between the PS/2 direction decoder, the update-clock tick, the apple/collision logic and the body RAM that the VGA renderer also reads.

Parameters:
- MAX_LEN, 128, body RAM depth and maximum snake length (power of 2).
- CELL, 10, step size in pixels per move.
- X_MIN, 10 / X_MAX, 620, legal head x range, inclusive.
- Y_MIN, 10 / Y_MAX, 460, legal head y range, inclusive.
- START_X, 320 / START_Y, 240, head position after init.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  game enable level; low means idle/restart
- tick  in  1  one-cycle step request, already synchronous to clk
- dir  in  3  000 right, 001 down, 010 left, 011 up; other codes keep the previous direction
- grow  in  1  one-cycle apple-eaten pulse
- mem_addr  out  7  body RAM address (log2 MAX_LEN)
- mem_we  out  1  body RAM write enable
- mem_wx  out  10  write data x / mem_wy  out  9  write data y
- mem_rx  in  10  read data x / mem_ry  in  9  read data y; valid 1 cycle after mem_addr
- length  out  7  current length minus 1 (0 means 1 segment)
- head_x  out  10 / head_y  out  9  current head position
- busy  out  1  high in any state other than IDLE, WAIT or OVER
- step_done  out  1  one-cycle pulse when a step completes
- game_over  out  1  sticky lethal-collision flag

Behaviour:
- Reset values:
  - state IDLE; mem_we 0; mem_addr 0; mem_wx and mem_wy 0.
  - length 0; head_x START_X; head_y START_Y; cur_dir 000.
  - grow_pend 0; busy 0; step_done 0; game_over 0.
- States: IDLE, INIT, WAIT, CALC, SCAN, SHIFT, HEAD, OVER.
- IDLE: on start=1, go to INIT.
- INIT (1 cycle):
  - Write (START_X, START_Y) to addr 0.
  - length 0; game_over 0; grow_pend 0; cur_dir 000.
  - Next state WAIT.
- WAIT:
  - tick=1 latches dir into cur_dir when dir is valid and is not the exact reverse of cur_dir; otherwise cur_dir holds.
  - Next state CALC.
- CALC (1 cycle):
  - nx = head_x ± CELL, ny = head_y ± CELL, using modulo 2^10 / 2^9 arithmetic.
  - Underflow wraps to a large value, which the unsigned border check catches.
  - If nx<X_MIN, nx>X_MAX, ny<Y_MIN or ny>Y_MAX: set game_over, go to OVER.
  - Otherwise set g = grow_pend && length<MAX_LEN-1, and go to SCAN.
- SCAN:
  - Compares (nx,ny) against old entries 0..E, where E = length if g else length-1. The tail vacates unless the snake grows.
  - One address per cycle; comparisons are pipelined by the 1-cycle read latency.
  - If length=0 and g=0, the scan is skipped.
  - Any match: set game_over, go to OVER (no RAM writes occur in this step).
  - No match: go to SHIFT.
- SHIFT:
  - For i from length+g down to 1: read addr i-1, then write addr i on the next cycle. That is 2 cycles per entry, with reads and writes never in the same cycle.
- HEAD (1 cycle):
  - Write (nx,ny) to addr 0; head_x/head_y <= nx/ny.
  - length <= length+g; if g, clear grow_pend.
  - step_done=1; return to WAIT.
- grow:
  - Sets grow_pend in any state except IDLE and INIT.
  - A grow arriving in the same cycle as HEAD consumes grow_pend leaves grow_pend=1.
  - At length=MAX_LEN-1, growth is ignored and grow_pend stays set.
- tick outside WAIT is dropped (no queueing).
- OVER: holds all outputs, game_over=1, no RAM writes; start=0 -> IDLE.
- start=0 in any state: IDLE on the next cycle. mem_we is forced to 0 that cycle. game_over and length are held until the next INIT.
- rst mid-step: immediate return to reset values. RAM contents are undefined to consumers until INIT.
- Step latency from tick (with g=0, L=length): 1 (CALC) + L (+1 when L>0) (SCAN) + 2L (SHIFT) + 1 (HEAD) cycles, then step_done.

Decomposition:
- Shared package snake_pkg holds:
  - direction codes DIR_RIGHT/DOWN/LEFT/UP;
  - MAX_LEN, CELL and the field bounds;
  - the state encoding.
- One natural sub-module: snake_body_ram, a single-port 128x19 synchronous RAM with 1-cycle read latency. The bench instantiates it alongside the DUT.

Test Plan:
- Reset, then start=1 -> INIT writes (320,240) to addr 0; length=0; after 1 tick with dir=000, head=(330,240) and step_done 3 cycles after tick (L=0: CALC 1, SCAN skipped, SHIFT 0, HEAD 1).
- grow pulse, then 3 ticks with dir=001 -> length=1 after the first step; RAM[0]=(330,250), RAM[1]=(330,240); grow_pend=0.
- Head at (330,20), dir=011 twice -> y=10 is legal, then y=0 -> game_over=1, state OVER; RAM unchanged in the failing step.
- Length 4 in a 2x2 loop (R, D, L, U) -> next head equals a body entry -> game_over=1; start=0 then start=1 -> length=0, head (320,240), game_over=0.
- dir=010 while moving right, and dir=111 -> cur_dir stays 000; head advances +10 in x.
- tick while busy, and rst asserted in the middle of SHIFT -> extra tick ignored; after rst, all outputs at reset values and state IDLE.
